// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MULT/DIV sequencer for the MIPS EX stage; drives the shared ALU one step per clock.
// Optional signed operation is enabled by defining SIGNED_MULDIV_EN.
module alu_muldiv_sequencer #(
  parameter int         XLEN     = 32,
  parameter logic [3:0] ALU_ADD  = 4'b0010,
  parameter logic [3:0] ALU_SUB  = 4'b0110,
  parameter logic [3:0] ALU_IDLE = 4'b0000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs_data,
  input  logic [XLEN-1:0] i_rt_data,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [3:0]      o_alu_ctrl,
  input  logic [XLEN-1:0] i_alu_result,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_div_by_zero,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

`ifdef SIGNED_MULDIV_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [4:0]        r_cnt;
  logic              r_is_div, r_neg_a, r_neg_b;
  logic [XLEN-1:0]   r_opa, r_opb, r_m, r_hi, r_lo;
  logic              r_busy, r_done, r_dz;
  logic              w_div0, w_carry, w_borrow;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic [2*XLEN-1:0] w_prod_neg;

  // opB is kept raw for the whole op, so the zero-divisor test stays valid through DONE
  assign w_div0     = r_is_div && (r_opb == '0);
  assign w_mag_a    = r_neg_a ? -r_opa : r_opa;
  assign w_mag_b    = r_neg_b ? -r_opb : r_opb;
  assign w_prod_neg = -{r_hi, r_lo};

  assign w_carry  = (o_alu_a[XLEN-1] & o_alu_b[XLEN-1]) |
                    ((o_alu_a[XLEN-1] | o_alu_b[XLEN-1]) & ~i_alu_result[XLEN-1]);
  assign w_borrow = (~o_alu_a[XLEN-1] & o_alu_b[XLEN-1]) |
                    (~(o_alu_a[XLEN-1] ^ o_alu_b[XLEN-1]) & i_alu_result[XLEN-1]);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_alu_a    = '0;
    o_alu_b    = '0;
    o_alu_ctrl = ALU_IDLE;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_LOAD;
      S_LOAD: w_next = w_div0 ? S_DONE : S_ITER;
      S_ITER: begin
        if (r_is_div) begin
          o_alu_a    = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
          o_alu_b    = r_m;
          o_alu_ctrl = ALU_SUB;
        end else begin
          o_alu_a    = r_hi;
          o_alu_b    = r_lo[0] ? r_m : '0;
          o_alu_ctrl = ALU_ADD;
        end
        if (r_cnt == 5'(XLEN-1)) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_m      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      // status outputs lag the state by one cycle
      r_busy <= (r_state == S_LOAD) || (r_state == S_ITER);
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: if (i_start) begin
          r_is_div <= i_op[0];
          r_neg_a  <= SIGNED_EN & i_op[1] & i_rs_data[XLEN-1];
          r_neg_b  <= SIGNED_EN & i_op[1] & i_rt_data[XLEN-1];
          r_opa    <= i_rs_data;
          r_opb    <= i_rt_data;
        end
        S_LOAD: begin
          r_dz  <= 1'b0;
          r_cnt <= '0;
          if (w_div0) begin
            r_hi <= r_opa;
            r_lo <= '1;
          end else if (r_is_div) begin
            r_hi <= '0;
            r_lo <= w_mag_a;
            r_m  <= w_mag_b;
          end else begin
            r_hi <= '0;
            r_lo <= w_mag_b;
            r_m  <= w_mag_a;
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt + 5'd1;
          if (!r_is_div) begin
            {r_hi, r_lo} <= {w_carry, i_alu_result, r_lo[XLEN-1:1]};
          end else if (r_hi[XLEN-1] | ~w_borrow) begin
            r_hi <= i_alu_result;
            r_lo <= {r_lo[XLEN-2:0], 1'b1};
          end else begin
            r_hi <= o_alu_a;
            r_lo <= {r_lo[XLEN-2:0], 1'b0};
          end
        end
        S_DONE: begin
          r_dz <= w_div0;
          if (!w_div0) begin
            if (!r_is_div) begin
              if (r_neg_a ^ r_neg_b) {r_hi, r_lo} <= w_prod_neg;
            end else begin
              if (r_neg_a ^ r_neg_b) r_lo <= -r_lo;
              if (r_neg_a)           r_hi <= -r_hi;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule
